// File: rtl/avg_pkg.sv
// Shared definitions for the averaging divider: FSM states and default widths.
package avg_pkg;

  localparam int DW_DEF = 16;
  localparam int NW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration; purely combinational.
module div_step #(
  parameter int DW = 16,
  parameter int NW = 8
) (
  input  logic [NW-1:0] rem_i,
  input  logic [DW-1:0] dvd_i,
  input  logic [NW-1:0] dvs_i,
  output logic [NW-1:0] rem_o,
  output logic [DW-2:0] dvd_o,
  output logic          qbit_o
);

  logic [NW:0] trial;
  logic [NW:0] dvs_ext;

  assign trial   = {rem_i, dvd_i[DW-1]};
  assign dvs_ext = {1'b0, dvs_i};
  assign qbit_o  = (trial >= dvs_ext);
  // A remainder that fails the compare is already below the divisor, so it fits in NW bits.
  assign rem_o   = qbit_o ? NW'(trial - dvs_ext) : trial[NW-1:0];
  assign dvd_o   = dvd_i[DW-2:0];

endmodule

// File: rtl/avg_div.sv
// Sequential unsigned sum/count divider, DW cycles per result (1 cycle for n == 0);
// start_i is ignored while busy_o is high, results hold in DONE until the next accepted start.
module avg_div
  import avg_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NW = NW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [DW-1:0] sum_i,
  input  logic [NW-1:0] n_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] quot_o,
  output logic [NW-1:0] rem_o,
  output logic          div_zero_o
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_t        state_q;
  logic [DW-1:0] dvd_q;
  logic [NW-1:0] dvs_q;
  logic [NW-1:0] rem_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] quot_q;
  logic [NW-1:0] remo_q;
  logic          done_q;
  logic          zero_q;

  logic [NW-1:0] rem_d;
  logic [DW-2:0] dvd_sh;
  logic          qbit;
  logic [DW-1:0] dvd_d;

  div_step #(
    .DW(DW),
    .NW(NW)
  ) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .dvd_o (dvd_sh),
    .qbit_o(qbit)
  );

  // Quotient bits fill the dividend register from the bottom as its bits are consumed.
  assign dvd_d = {dvd_sh, qbit};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            if (n_i == '0) begin
              state_q <= DONE;
              quot_q  <= '1;
              remo_q  <= '0;
              done_q  <= 1'b1;
              zero_q  <= 1'b1;
            end else begin
              state_q <= CALC;
              dvd_q   <= sum_i;
              dvs_q   <= n_i;
              rem_q   <= '0;
              cnt_q   <= '0;
              done_q  <= 1'b0;
              zero_q  <= 1'b0;
            end
          end
        end
        CALC: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= DONE;
            quot_q  <= dvd_d;
            remo_q  <= rem_d;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o     = (state_q == CALC);
  assign done_o     = done_q;
  assign quot_o     = quot_q;
  assign rem_o      = remo_q;
  assign div_zero_o = zero_q;

endmodule

// File: tb/tb_avg_div.sv
// Scoreboard bench for avg_div: directed cases plus randomized divisions against an arithmetic model.
module tb_avg_div;

  localparam int DW = 16;
  localparam int NW = 8;

  logic          clk;
  logic          rst;
  logic          start_i;
  logic [DW-1:0] sum_i;
  logic [NW-1:0] n_i;
  logic          busy_o;
  logic          done_o;
  logic [DW-1:0] quot_o;
  logic [NW-1:0] rem_o;
  logic          div_zero_o;

  avg_div #(.DW(DW), .NW(NW)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start_i),
    .sum_i     (sum_i),
    .n_i       (n_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .quot_o    (quot_o),
    .rem_o     (rem_o),
    .div_zero_o(div_zero_o)
  );

  typedef struct {
    int            acc;
    int            due;
    logic [DW-1:0] q;
    logic [NW-1:0] r;
    logic          z;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  int   edges = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_due = 0;
  logic mon_en = 1'b0;

  logic [DW-1:0] held_q;
  logic [NW-1:0] held_r;
  logic          held_z;
  logic          held_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, edges);
    end
  endtask

  // Monitor: samples on the falling edge, before the driver touches anything (+1 time unit).
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        held_q    = '0;
        held_r    = '0;
        held_z    = 1'b0;
        held_done = 1'b0;
      end
      if (sb.size() > 0 && sb[0].due == edges) begin
        cur = sb.pop_front();
        chk("done_at_due", {31'd0, done_o}, 32'd1);
        chk("quot", {16'd0, quot_o}, {16'd0, cur.q});
        chk("rem", {24'd0, rem_o}, {24'd0, cur.r});
        chk("div_zero", {31'd0, div_zero_o}, {31'd0, cur.z});
        chk("busy_at_done", {31'd0, busy_o}, 32'd0);
        held_q    = cur.q;
        held_r    = cur.r;
        held_z    = cur.z;
        held_done = 1'b1;
      end else if (sb.size() > 0) begin
        chk("busy_in_calc", {31'd0, busy_o}, 32'd1);
        chk("done_in_calc", {31'd0, done_o}, 32'd0);
        chk("zero_in_calc", {31'd0, div_zero_o}, 32'd0);
        chk("quot_hold_calc", {16'd0, quot_o}, {16'd0, held_q});
        chk("rem_hold_calc", {24'd0, rem_o}, {24'd0, held_r});
      end else begin
        chk("busy_idle", {31'd0, busy_o}, 32'd0);
        chk("done_hold", {31'd0, done_o}, {31'd0, held_done});
        chk("quot_hold", {16'd0, quot_o}, {16'd0, held_q});
        chk("rem_hold", {24'd0, rem_o}, {24'd0, held_r});
        chk("zero_hold", {31'd0, div_zero_o}, {31'd0, held_z});
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Drive one start pulse; the model decides whether the DUT can accept it.
  task automatic issue(input logic [DW-1:0] s, input logic [NW-1:0] n);
    exp_t e;
    @(negedge clk);
    #1;
    start_i = 1'b1;
    sum_i   = s;
    n_i     = n;
    if (edges >= last_due) begin
      e.acc = edges + 1;
      e.due = (n == 0) ? edges + 1 : edges + 1 + DW;
      e.q   = (n == 0) ? {DW{1'b1}} : s / DW'(n);
      e.r   = (n == 0) ? '0 : NW'(s % DW'(n));
      e.z   = (n == 0);
      sb.push_back(e);
      last_due = e.due;
    end
    @(negedge clk);
    #1;
    start_i = 1'b0;
    sum_i   = DW'($urandom);
    n_i     = NW'($urandom);
  endtask

  task automatic wait_done();
    while (edges < last_due) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    last_due = 0;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] s;
    logic [NW-1:0] n;
    rst     = 1'b1;
    start_i = 1'b0;
    sum_i   = '0;
    n_i     = '0;
    repeat (3) @(negedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    issue(16'd500, 8'd0);
    wait_done();
    idle(3);
    issue(16'd1000, 8'd10);
    wait_done();
    idle(2);
    issue(16'd1000, 8'd7);
    wait_done();
    issue(16'd65535, 8'd255);
    wait_done();
    idle(1);

    issue(16'd1000, 8'd10);
    idle(3);
    issue(16'd200, 8'd3);
    wait_done();
    issue(16'd300, 8'd4);
    wait_done();
    idle(2);

    issue(16'd1000, 8'd10);
    idle(7);
    do_reset();
    idle(20);
    issue(16'd90, 8'd9);
    wait_done();

    for (int i = 0; i < 40; i++) begin
      s = DW'($urandom);
      n = NW'($urandom);
      case ($urandom_range(0, 9))
        0: n = '0;
        1: n = 8'd1;
        2: n = 8'd255;
        3: s = 16'hFFFF;
        4: s = DW'($urandom_range(0, 300));
        default: ;
      endcase
      if (i == 20) do_reset();
      issue(s, n);
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(0, 12));
        issue(DW'($urandom), NW'($urandom_range(1, 255)));
      end
      wait_done();
      idle($urandom_range(0, 2));
    end

    idle(5);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avg_div.md
AVG_DIV -- requirements
Module: avg_div

Interface
REQ-001 SHALL have parameter DW, default 16, dividend (sum) width.
REQ-002 SHALL have parameter NW, default 8, divisor (count) width; NW <= DW.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start_i  input  1  request pulse; captures sum_i and n_i when accepted.
REQ-006 SHALL have port sum_i  input  DW  accumulated sum from the upstream summing stage.
REQ-007 SHALL have port n_i  input  NW  sample count; this is the divisor.
REQ-008 SHALL have port busy_o  output  1  high while a division is in progress.
REQ-009 SHALL have port done_o  output  1  level; result valid and held.
REQ-010 SHALL have port quot_o  output  DW  quotient (sum_i / n_i, truncated).
REQ-011 SHALL have port rem_o  output  NW  remainder.
REQ-012 SHALL have port div_zero_o  output  1  the last accepted request had n_i == 0.

Function
REQ-013 SHALL implement FSM states IDLE, CALC and DONE.
REQ-014 SHALL accept start_i only in IDLE or DONE; start_i in CALC SHALL be ignored, with no capture and no effect on the result.
REQ-015 On acceptance at edge k with n_i != 0:
- capture sum_i and n_i;
- clear the remainder register and the iteration counter;
- clear done_o and div_zero_o;
- go to CALC.
REQ-016 In CALC, each edge SHALL perform one restoring step:
- remainder (NW+1 bits) = {remainder, dividend MSB};
- shift the dividend left;
- if remainder >= divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
REQ-017 The iteration counter SHALL run 0..DW-1; at the edge with counter == DW-1, go to DONE, load quot_o and rem_o, and set done_o.
REQ-018 Latency SHALL be exactly DW cycles: done_o is first visible after edge k+DW (16 at default).
REQ-019 On acceptance with n_i == 0:
- go directly to DONE at edge k;
- quot_o = all ones, rem_o = 0;
- div_zero_o = 1, done_o = 1 (visible after edge k);
- no CALC cycles.
REQ-020 busy_o SHALL equal (state == CALC).
REQ-021 In DONE, quot_o, rem_o, div_zero_o and done_o SHALL hold until the next accepted start_i or reset.
REQ-022 A start_i accepted in DONE SHALL deassert done_o at the same edge and begin a new operation per REQ-015/REQ-019.
REQ-023 quot_o and rem_o SHALL NOT change during CALC; they update only at completion.
REQ-024 Arithmetic SHALL be unsigned; the remainder compare uses NW+1 bits so no overflow is possible.

Reset
REQ-025 rst_i high at an edge SHALL force IDLE, and clear quot_o, rem_o, done_o, busy_o, div_zero_o, the counter and all internal registers; this takes priority over start_i.
REQ-026 Reset during CALC SHALL abort the operation; no done_o pulse SHALL follow.

Structure
REQ-027 Shared package avg_pkg SHALL hold the FSM state enum (IDLE/CALC/DONE) and the default DW/NW constants.
REQ-028 A combinational sub-module div_step (one restoring iteration: remainder/dividend in -> remainder/dividend/quotient bit out) SHALL be used by the sequential top.
REQ-029 The block SHALL be synthesizable with no initial-value assignments; reset is the only initialization.

Verification
REQ-030 sum_i=1000, n_i=10, start pulse -> after 16 cycles done_o=1, quot_o=100, rem_o=0, div_zero_o=0.
REQ-031 sum_i=1000, n_i=7 -> quot_o=142, rem_o=6; sum_i=65535, n_i=255 -> quot_o=257, rem_o=0.
REQ-032 sum_i=500, n_i=0 -> done_o=1 after one edge, quot_o=16'hFFFF, rem_o=0, div_zero_o=1, busy_o never high.
REQ-033 start (1000/10), then start_i (200/3) pulsed at cycle 5 of CALC -> second request ignored, result 100 r0 at cycle 16.
REQ-034 Reset asserted at cycle 8 of CALC -> next edge IDLE, all outputs 0, done_o stays 0 for 20 further cycles; a new start 90/9 -> 10 r0.
REQ-035 Back-to-back: start in DONE with 300/4 -> done_o drops at the capture edge, 75 r0 after 16 cycles.
